// File: rtl/bus_source_arbiter.sv
// Registered bus source arbiter: picks one of N requesters (fixed priority or
// round-robin, with optional grant locking) and drives its data onto a registered bus.
module bus_source_arbiter #(
    parameter int WIDTH = 16,
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic [N-1:0]         select,
    input  logic                 mode,
    input  logic                 lock,
    output logic [WIDTH-1:0]     bus,
    output logic [N-1:0]         grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 bus_valid,
    output logic                 dbg_state,
    output logic [IDX_W-1:0]     dbg_rr_ptr
);

    // Handshake: select[i] is a level request, granted source is reported one
    // cycle later on grant/grant_idx with bus_valid=1; no ready/backpressure.

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_bus, w_bus_nxt;
    logic [N-1:0]       r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_valid, w_valid_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;

    logic               w_fp_found, w_rr_found, w_arb_found;
    logic [IDX_W-1:0]   w_fp_idx, w_rr_idx, w_arb_idx;
    logic               w_hold;

    // Fixed priority: scanning downward leaves the lowest asserted index.
    always_comb begin
        w_fp_found = 1'b0;
        w_fp_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (select[i]) begin
                w_fp_found = 1'b1;
                w_fp_idx   = IDX_W'(i);
            end
        end
    end

    // Round-robin: same trick, scanning offsets from rr_ptr downward with wrap.
    always_comb begin : rr_search
        int j;
        j          = 0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(r_rr_ptr) + k;
            if (j >= N) j = j - N;
            if (select[j]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(j);
            end
        end
    end

    assign w_arb_found = mode ? w_rr_found : w_fp_found;
    assign w_arb_idx   = mode ? w_rr_idx   : w_fp_idx;
    assign w_hold      = (r_state == GRANTED) && select[r_idx] && lock;

    always_comb begin
        w_state_nxt = IDLE;
        w_bus_nxt   = '0;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE, GRANTED: begin
                if (w_hold) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = r_grant;
                    w_idx_nxt   = r_idx;
                    w_valid_nxt = 1'b1;
                    w_bus_nxt   = data_in[int'(r_idx)*WIDTH +: WIDTH];
                end else if (w_arb_found) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_arb_idx;
                    w_idx_nxt   = w_arb_idx;
                    w_valid_nxt = 1'b1;
                    w_bus_nxt   = data_in[int'(w_arb_idx)*WIDTH +: WIDTH];
                    w_rr_nxt    = (w_arb_idx == IDX_W'(N - 1)) ? '0 : w_arb_idx + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bus    <= '0;
            r_grant  <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bus    <= w_bus_nxt;
            r_grant  <= w_grant_nxt;
            r_idx    <= w_idx_nxt;
            r_valid  <= w_valid_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign bus        = r_bus;
    assign grant      = r_grant;
    assign grant_idx  = r_idx;
    assign bus_valid  = r_valid;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: directed scenarios then random traffic on a
// 10x16 instance and a 5x8 instance, each checked against a request-list model.
module tb_bus_source_arbiter;

    logic          clock;
    logic          reset;
    logic          mode;
    logic          lock;

    logic [159:0]  a_data;
    logic [9:0]    a_sel;
    logic [15:0]   a_bus;
    logic [9:0]    a_grant;
    logic [3:0]    a_idx;
    logic          a_valid;
    logic          a_state;
    logic [3:0]    a_rr;

    logic [39:0]   b_data;
    logic [4:0]    b_sel;
    logic [7:0]    b_bus;
    logic [4:0]    b_grant;
    logic [2:0]    b_idx;
    logic          b_valid;
    logic          b_state;
    logic [2:0]    b_rr;

    int            n_cmp = 0;
    int            n_bad = 0;

    int            m_held[2];
    int            m_rr[2];
    logic [255:0]  m_bus[2];

    bus_source_arbiter #(.WIDTH(16), .N(10), .IDX_W(4)) u_a (
        .clock(clock), .reset(reset), .data_in(a_data), .select(a_sel),
        .mode(mode), .lock(lock), .bus(a_bus), .grant(a_grant),
        .grant_idx(a_idx), .bus_valid(a_valid), .dbg_state(a_state), .dbg_rr_ptr(a_rr)
    );

    bus_source_arbiter #(.WIDTH(8), .N(5), .IDX_W(3)) u_b (
        .clock(clock), .reset(reset), .data_in(b_data), .select(b_sel),
        .mode(mode), .lock(lock), .bus(b_bus), .grant(b_grant),
        .grant_idx(b_idx), .bus_valid(b_valid), .dbg_state(b_state), .dbg_rr_ptr(b_rr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [255:0] field(input logic [255:0] data, input int i, input int wd);
        return (data >> (i * wd)) & ((256'd1 << wd) - 256'd1);
    endfunction

    // Reference: the holder keeps the bus while locked and still requesting;
    // otherwise the first requester in priority or rotation order wins.
    task automatic model_step(input int k, input int n, input int wd,
                              input logic [15:0] sel, input logic [255:0] data);
        int w;
        w = -1;
        if (reset) begin
            m_held[k] = -1;
            m_rr[k]   = 0;
            m_bus[k]  = '0;
        end else if (m_held[k] >= 0 && sel[m_held[k]] && lock) begin
            m_bus[k] = field(data, m_held[k], wd);
        end else begin
            if (!mode) begin
                for (int i = 0; i < n; i++)
                    if (sel[i] && w < 0) w = i;
            end else begin
                for (int i = 0; i < n; i++) begin
                    int c;
                    c = (m_rr[k] + i) % n;
                    if (sel[c] && w < 0) w = c;
                end
            end
            if (w >= 0) begin
                m_held[k] = w;
                m_rr[k]   = (w + 1) % n;
                m_bus[k]  = field(data, w, wd);
            end else begin
                m_held[k] = -1;
                m_bus[k]  = '0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string tag, input int k, input logic [255:0] bus_o,
                             input logic [255:0] grant_o, input logic [255:0] idx_o,
                             input logic [255:0] valid_o, input logic [255:0] state_o,
                             input logic [255:0] rr_o);
        logic [255:0] e_grant;
        e_grant = (m_held[k] < 0) ? 256'd0 : (256'd1 << m_held[k]);
        chk($sformatf("%s.%0d.bus", tag, k), bus_o, m_bus[k]);
        chk($sformatf("%s.%0d.grant", tag, k), grant_o, e_grant);
        chk($sformatf("%s.%0d.idx", tag, k), idx_o, 256'((m_held[k] < 0) ? 0 : m_held[k]));
        chk($sformatf("%s.%0d.valid", tag, k), valid_o, 256'(m_held[k] >= 0));
        chk($sformatf("%s.%0d.state", tag, k), state_o, 256'(m_held[k] >= 0));
        chk($sformatf("%s.%0d.rr", tag, k), rr_o, 256'(m_rr[k]));
    endtask

    task automatic tick(input string tag);
        model_step(0, 10, 16, 16'(a_sel), 256'(a_data));
        model_step(1, 5, 8, 16'(b_sel), 256'(b_data));
        @(posedge clock);
        #1;
        check_one(tag, 0, 256'(a_bus), 256'(a_grant), 256'(a_idx), 256'(a_valid),
                  256'(a_state), 256'(a_rr));
        check_one(tag, 1, 256'(b_bus), 256'(b_grant), 256'(b_idx), 256'(b_valid),
                  256'(b_state), 256'(b_rr));
    endtask

    task automatic rand_data();
        a_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b_data = {8'($urandom), $urandom};
    endtask

    initial begin
        int exp_b[6];
        logic [15:0] cnt;
        exp_b = '{0, 2, 4, 0, 2, 4};
        m_held = '{-1, -1};
        m_rr   = '{0, 0};
        m_bus  = '{256'd0, 256'd0};

        // reset with every request high
        reset = 1'b1; mode = 1'b0; lock = 1'b0;
        a_sel = 10'h3FF; b_sel = 5'h1F;
        rand_data();
        tick("rst");
        chk("rst_bus_zero", 256'(a_bus), 256'd0);
        chk("rst_valid_zero", 256'(a_valid), 256'd0);

        // scenario 1: first grant goes to source 0
        reset = 1'b0;
        a_data[15:0] = 16'h1234;
        tick("s1");
        chk("s1_bus", 256'(a_bus), 256'h1234);
        chk("s1_grant", 256'(a_grant), 256'h001);

        // scenario 2: fixed priority, then holder drops
        a_sel = 10'h00C;
        a_data[2*16 +: 16] = 16'hAAAA;
        a_data[3*16 +: 16] = 16'hBBBB;
        for (int i = 0; i < 3; i++) begin
            tick("s2_steady");
            chk("s2_bus_aaaa", 256'(a_bus), 256'hAAAA);
        end
        a_sel = 10'h008;
        tick("s2_drop");
        chk("s2_bus_bbbb", 256'(a_bus), 256'hBBBB);
        chk("s2_grant", 256'(a_grant), 256'h008);

        // scenario 3: round-robin over three requesters with wrap
        mode = 1'b1;
        a_sel = 10'h205;
        for (int i = 0; i < 9; i++) begin
            rand_data();
            tick("s3_rr");
        end

        // scenario 4: lock on source 4 while everyone requests
        lock = 1'b0;
        a_sel = 10'h010;
        tick("s4_get");
        chk("s4_idx4", 256'(a_idx), 256'd4);
        lock = 1'b1;
        a_sel = 10'h3FF;
        cnt = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 16'd1;
            a_data[4*16 +: 16] = cnt;
            tick("s4_lock");
            chk("s4_grant_held", 256'(a_grant), 256'h010);
            chk("s4_bus_track", 256'(a_bus), 256'(cnt));
        end
        lock = 1'b0;
        tick("s4_unlock");
        chk("s4_next_idx5", 256'(a_idx), 256'd5);

        // scenario 5: grant on 7, all drop, re-request
        a_sel = 10'h080;
        tick("s5_get");
        chk("s5_idx7", 256'(a_idx), 256'd7);
        a_sel = 10'h000;
        tick("s5_idle");
        chk("s5_grant_zero", 256'(a_grant), 256'd0);
        chk("s5_bus_zero", 256'(a_bus), 256'd0);
        a_sel = 10'h080;
        tick("s5_regrant");
        chk("s5_grant_080", 256'(a_grant), 256'h080);

        // scenario 6: reset mid-lock, rr pointer restarts at 0
        lock = 1'b1;
        a_sel = 10'h3FF;
        b_sel = 5'h15;
        tick("s6_locked");
        reset = 1'b1;
        tick("s6_reset");
        chk("s6_grant_zero", 256'(a_grant), 256'd0);
        chk("s6_rr_zero", 256'(a_rr), 256'd0);
        reset = 1'b0;
        lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            tick("s6_rr");
            if (i == 0) chk("s6_first_idx0", 256'(a_idx), 256'd0);
            chk($sformatf("s6_b_idx%0d", i), 256'(b_idx), 256'(exp_b[i]));
        end

        // random traffic, including lock/drop collisions and stray resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            lock = ($urandom_range(0, 2) == 0);
            a_sel = ($urandom_range(0, 5) == 0) ? 10'h0 : 10'($urandom & $urandom);
            b_sel = ($urandom_range(0, 5) == 0) ? 5'h0 : 5'($urandom & $urandom);
            rand_data();
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Parametrised, registered successor to the datapath bus source multiplexer.
- Arbitrates N request/select lines. Source order: 0 = immediate, 1 = ALU result R, 2..9 = r0..r7 by default.
- Drives a registered WIDTH-bit datapath bus with grant, index and valid outputs.
- Adds runtime fixed-priority/round-robin mode, grant locking and a one-cycle registered output stage, so the control FSM sees a stable bus.

Parameters:
- WIDTH, 16, bus and per-source data width in bits.
- N, 10, number of bus sources (2..16).
- IDX_W, 4, width of grant index; must satisfy 2**IDX_W >= N.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  N*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- select  input  N  per-source request; multiple bits may be high.
- mode  input  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- lock  input  1  1 = hold current grant while its select stays high.
- bus  output  WIDTH  registered selected data.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_idx  output  IDX_W  registered index of granted source; 0 when idle.
- bus_valid  output  1  registered; 1 when grant is non-zero.

Behaviour:
- Reset (sync, active-high):
  - Values: bus=0, grant=0, grant_idx=0, bus_valid=0, rr_ptr=0, state=IDLE.
  - Reset dominates all other inputs at the edge.
  - Mid-grant reset drops the grant in the following cycle.
- States: IDLE, GRANTED. All outputs are registered; no combinational path from select/data_in to bus.
- Arbitration (evaluated each cycle when re-arbitration is required):
  - mode=0: lowest-index asserted select wins.
  - mode=1: search starts at rr_ptr and wraps from N-1 to 0; first asserted select wins.
  - rr_ptr updates to (winner+1) mod N on every new grant, in both modes.
  - mode is sampled only at arbitration edges; a change while locked takes effect at the next arbitration.
- IDLE:
  - select==0: stay IDLE; bus=0, bus_valid=0.
  - Any select: at this edge, register the winner into grant/grant_idx, set bus=data of winner, set bus_valid=1, go to GRANTED.
  - Latency is one cycle from select to bus.
- GRANTED, granted select high, lock=1: keep grant. bus reloads the granted source's current data every cycle, so data changes appear one cycle later.
- GRANTED, granted select high, lock=0: re-arbitrate every cycle, with the current holder eligible.
  - mode=1 rotates fairly among requesters.
  - mode=0 keeps the highest-priority source.
- GRANTED, granted select low: re-arbitrate among the remaining selects in the same edge (lock is ignored).
  - Any remaining select: switch grant with no idle bubble.
  - None: return to IDLE; bus=0, grant=0, bus_valid=0 at that edge.
- Simultaneous events:
  - New requests arriving while locked are ignored until the lock ends or the holder drops.
  - Holder drop and lock assertion in the same cycle: the drop wins.
- Invariants:
  - grant is always one-hot or zero.
  - bus_valid == |grant.
  - grant_idx matches grant.
  - bus==0 whenever bus_valid==0.
- Width:
  - data passes unmodified; no arithmetic on data.
  - rr_ptr wraps mod N and is never >= N, including non-power-of-two N.

Test Plan:
1. Reset with all select=1 → next cycle bus=0, grant=0, bus_valid=0. Release reset, mode=0, select=0x3FF, data source0=0x1234 → one cycle later bus=0x1234, grant=0x001, grant_idx=0.
2. mode=0, lock=0, select=0x00C (src2=0xAAAA, src3=0xBBBB) → bus=0xAAAA steady. Drop bit2 → next cycle bus=0xBBBB, grant=0x008, bus_valid stays 1.
3. mode=1, lock=0, select=0x205 held → grants cycle idx 0,2,9,0,2,9...; rr_ptr wrap 9→0 verified.
4. mode=1, lock=1, grant on src4, select=0x3FF, src4 data incremented each cycle → grant stays 0x010 for 8 cycles; bus tracks data with 1-cycle lag. Deassert lock → next grant idx 5.
5. Grant on src7, drop all selects → next cycle bus=0, grant=0, grant_idx=0, bus_valid=0, state IDLE. Re-assert select=0x080 → grant again after 1 cycle.
6. Reset asserted mid-lock with select=0x3FF → outputs zero next cycle. After release with mode=1, first grant is idx 0 (rr_ptr reset). Rerun scenario 3 with N=5, WIDTH=8 for parameter coverage.
